// File: rtl/sfp_link_monitor.sv
// Per-channel link-up synchroniser/debouncer, drop counters (SFP_LINK_MON_DROP_CNT_EN) and status LEDs.
// All outputs are registered; link_stable lags a steady input change by DEBOUNCE_CYCLES+2 cycles; no backpressure.
module sfp_link_monitor #(
    parameter int SFP_COUNT       = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 25000000,
    parameter int DROP_CNT_W      = 16,
    localparam int CH_W           = (SFP_COUNT > 1) ? $clog2(SFP_COUNT) : 1
) (
    input  logic                  sysclk_100m,
    input  logic                  sys_reset,
    input  logic [SFP_COUNT-1:0]  link_up_in,
    input  logic [CH_W-1:0]       cnt_sel,
    input  logic                  cnt_clr,
    output logic [SFP_COUNT-1:0]  link_stable,
    output logic                  all_stable,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [1:0]            sleds
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int HB_W = $clog2(BLINK_CYCLES);
    localparam int BT_W = $clog2(2 * BLINK_CYCLES);
    localparam int N_W  = $clog2(SFP_COUNT + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0] HB_LAST  = HB_W'(BLINK_CYCLES - 1);
    localparam logic [BT_W-1:0] PH_LAST  = BT_W'(BLINK_CYCLES - 1);
    localparam logic [BT_W-1:0] GAP_LAST = BT_W'(2 * BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_GAP,
        S_ON,
        S_OFF
    } blink_state_e;

    logic [SFP_COUNT-1:0]  sync1_q, sync2_q;
    logic [SFP_COUNT-1:0]  stable_q, stable_d;
    logic [DB_W-1:0]       db_cnt_q [SFP_COUNT];
    logic [DB_W-1:0]       db_cnt_d [SFP_COUNT];
    logic                  all_stable_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_sel;

    logic [HB_W-1:0]       hb_tmr_q, hb_tmr_d;
    logic                  led0_q, led0_d;

    blink_state_e          state_q, state_d;
    logic [BT_W-1:0]       bl_tmr_q, bl_tmr_d;
    logic [N_W-1:0]        rem_q, rem_d;
    logic [N_W-1:0]        n_links;
    logic                  led1_q, led1_d;

    // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < SFP_COUNT; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysclk_100m) begin
        if (sys_reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            all_stable_q <= 1'b0;
            for (int i = 0; i < SFP_COUNT; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= link_up_in;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            all_stable_q <= &stable_q;
            for (int i = 0; i < SFP_COUNT; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

`ifdef SFP_LINK_MON_DROP_CNT_EN
    logic [SFP_COUNT-1:0]  stable_prev_q;
    logic [SFP_COUNT-1:0]  fall;
    logic [DROP_CNT_W-1:0] drop_q [SFP_COUNT];
    logic [DROP_CNT_W-1:0] drop_d [SFP_COUNT];

    assign fall = stable_prev_q & ~stable_q;

    // Clear coinciding with a drop leaves 1 so the new drop is not lost.
    always_comb begin
        drop_sel = '0;
        for (int i = 0; i < SFP_COUNT; i++) begin
            drop_d[i] = drop_q[i];
            if (cnt_clr && (32'(cnt_sel) == i)) begin
                drop_d[i] = fall[i] ? DROP_CNT_W'(1) : '0;
            end else if (fall[i] && (drop_q[i] != '1)) begin
                drop_d[i] = drop_q[i] + 1'b1;
            end
            if (32'(cnt_sel) == i) begin
                drop_sel = drop_q[i];
            end
        end
    end

    always_ff @(posedge sysclk_100m) begin
        if (sys_reset) begin
            stable_prev_q <= '0;
            for (int i = 0; i < SFP_COUNT; i++) begin
                drop_q[i] <= '0;
            end
        end else begin
            stable_prev_q <= stable_q;
            for (int i = 0; i < SFP_COUNT; i++) begin
                drop_q[i] <= drop_d[i];
            end
        end
    end
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = ^{cnt_sel, cnt_clr};
    assign drop_sel          = '0;
`endif

    always_comb begin
        n_links = '0;
        for (int i = 0; i < SFP_COUNT; i++) begin
            n_links = n_links + N_W'(stable_q[i]);
        end
    end

    always_comb begin
        hb_tmr_d = (hb_tmr_q == HB_LAST) ? '0 : hb_tmr_q + 1'b1;
        if (all_stable_q) begin
            led0_d = 1'b1;
        end else if (hb_tmr_q == HB_LAST) begin
            led0_d = ~led0_q;
        end else begin
            led0_d = led0_q;
        end
    end

    // Blink code: n is sampled only at the end of GAP, so a running sequence ignores link changes.
    always_comb begin
        state_d  = state_q;
        bl_tmr_d = bl_tmr_q + 1'b1;
        rem_d    = rem_q;
        case (state_q)
            S_GAP: begin
                if (bl_tmr_q == GAP_LAST) begin
                    bl_tmr_d = '0;
                    if (n_links != '0) begin
                        state_d = S_ON;
                        rem_d   = n_links;
                    end
                end
            end
            S_ON: begin
                if (bl_tmr_q == PH_LAST) begin
                    bl_tmr_d = '0;
                    state_d  = S_OFF;
                end
            end
            S_OFF: begin
                if (bl_tmr_q == PH_LAST) begin
                    bl_tmr_d = '0;
                    rem_d    = rem_q - 1'b1;
                    state_d  = (rem_q == N_W'(1)) ? S_GAP : S_ON;
                end
            end
            default: begin
                state_d  = S_GAP;
                bl_tmr_d = '0;
            end
        endcase
        led1_d = (state_d == S_ON);
    end

    always_ff @(posedge sysclk_100m) begin
        if (sys_reset) begin
            drop_cnt_q <= '0;
            hb_tmr_q   <= '0;
            led0_q     <= 1'b0;
            state_q    <= S_GAP;
            bl_tmr_q   <= '0;
            rem_q      <= '0;
            led1_q     <= 1'b0;
        end else begin
            drop_cnt_q <= drop_sel;
            hb_tmr_q   <= hb_tmr_d;
            led0_q     <= led0_d;
            state_q    <= state_d;
            bl_tmr_q   <= bl_tmr_d;
            rem_q      <= rem_d;
            led1_q     <= led1_d;
        end
    end

    assign link_stable = stable_q;
    assign all_stable  = all_stable_q;
    assign drop_cnt    = drop_cnt_q;
    assign sleds       = {led1_q, led0_q};

endmodule
